load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit that sits directly upstream of the byte-addressed data memory in the multi-cycle RV32I core. It accepts one load or store request at a time from the memory stage and checks alignment and address range. It drives a word-wide memory port with byte enables, then returns sign/zero-extended load data or a store completion. Memory access is sequenced by an explicit state machine with a parameterised read latency.

## Interface
- ADDR_WIDTH, 16, byte-address width of data memory (64 KiB); addresses at or above 2**ADDR_WIDTH fault.
- MEM_LATENCY, 1, cycles from `mem_en` (read) to valid `mem_rdata`; legal range 1..7.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE and rst low.
- req_is_store  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend (lbu/lhu).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  response present; held until accepted.
- resp_ready  input  1  consumer accepts response.
- resp_data  output  32  extended load data; 0 for stores and faults.
- resp_misaligned  output  1  alignment or illegal-size fault.
- resp_fault  output  1  address out of range.
- mem_en  output  1  memory access strobe, exactly one cycle per access.
- mem_we  output  1  write strobe, qualified by mem_en.
- mem_be  output  4  byte enables; bit i = byte lane i.
- mem_addr  output  ADDR_WIDTH-2  word address (req_addr[ADDR_WIDTH-1:2]).
- mem_wdata  output  32  lane-replicated store data.
- mem_rdata  input  32  read word, valid MEM_LATENCY cycles after mem_en.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: on req_valid & req_ready, register all request fields. Also register the fault flags.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0; size 11 always misaligned.
- Out of range: req_addr[31:ADDR_WIDTH] ≠ 0.
- If either flag is set, go to RESP. No memory access occurs. Misaligned takes priority only in the sense that both flags may be set together.
- Otherwise go to ISSUE.
- ISSUE: mem_en=1 for one cycle. mem_we = is_store.
  - Byte enables: byte 0001<<a; half 0011<<a; word 1111 (a = addr[1:0]).
  - mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
  - Store: go to RESP. Load: load the latency counter with MEM_LATENCY and go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reaches 1, capture mem_rdata and go to RESP.
- Load extraction: shift the captured word right by 8·a. Byte/half are sign-extended from bit 7/15 unless req_unsigned; word is passed through.
- RESP: resp_valid=1 with stable data and flags. On resp_ready, go to IDLE.
- mem_en, mem_we and mem_be are 0 in every state except ISSUE.

## Timing
- Reset (async assert): state IDLE. All outputs are 0, including req_ready, resp_valid, resp_data, both flags, mem_en, mem_we, mem_be, mem_addr and mem_wdata.
- rst mid-operation: the operation is abandoned with no response. Any in-flight mem_en/mem_we drops immediately.
- Cycle 0 is the acceptance edge.
  - Fault: resp_valid in cycle 1.
  - Store: mem_en in cycle 1, resp_valid in cycle 2.
  - Load: mem_en in cycle 1, rdata sampled at the end of cycle 1+MEM_LATENCY, resp_valid in cycle 2+MEM_LATENCY (cycle 3 at default).
- req_ready falls the cycle after acceptance. It returns in the cycle after resp_valid & resp_ready.
- Back-to-back throughput: store every 3 cycles; load every 3+MEM_LATENCY cycles (with resp_ready held high).
- resp_ready held low: RESP persists indefinitely and all response outputs stay constant.
- req_valid while not ready is ignored. Request inputs are don't-care outside the acceptance edge.

## Test plan
- Reset: assert rst mid-WAIT -> all outputs 0 immediately; after release, req_ready=1 and no stale resp_valid appears.
- Store byte: addr 0x0000_0103, wdata 0x1234_56AB -> cycle 1 shows mem_en=1, mem_we=1, mem_be=1000, mem_addr=0x040, mem_wdata=0xABAB_ABAB; resp_valid in cycle 2 with resp_data=0.
- Signed/unsigned load: memory word 0x80F0_7F01 at 0x200, default latency.
  - lh at 0x202 -> resp_data 0xFFFF_80F0 in cycle 3.
  - lhu at 0x202 -> 0x0000_80F0.
  - lb at 0x201 -> 0x0000_007F.
- Misalignment: lw at 0x0000_0102 -> resp_misaligned=1 in cycle 1, mem_en never asserted. size=11 at 0x0 -> resp_misaligned=1.
- Range: sw at 0x0001_0000 (ADDR_WIDTH=16) -> resp_fault=1, no mem_en.
- Backpressure and latency: MEM_LATENCY=3, lw with resp_ready low for 5 cycles -> resp_valid from cycle 5, data constant; req_ready=0 throughout; IDLE is reached the cycle after resp_ready rises.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit for the multi-cycle RV32I core: alignment and range
// checks, word-wide memory sequencing, and load data extension.
module load_store_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_misaligned,
  output logic                  resp_fault,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic          is_store_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [1:0]    lane_q;
  logic [WW-1:0] waddr_q;
  logic [31:0]   wdata_q;
  logic          mis_q;
  logic          flt_q;
  logic [31:0]   data_q;
  logic [2:0]    cnt_q;

  logic          mis_c;
  logic          flt_c;
  logic [3:0]    be_c;
  logic [31:0]   wrep_c;
  logic [31:0]   shift_c;
  logic [31:0]   ext_c;

  // Request checks, evaluated on the live inputs at acceptance.
  always_comb begin
    mis_c = 1'b0;
    unique case (req_size)
      2'b00:   mis_c = 1'b0;
      2'b01:   mis_c = req_addr[0];
      2'b10:   mis_c = |req_addr[1:0];
      default: mis_c = 1'b1;
    endcase
  end

  assign flt_c = |req_addr[31:ADDR_WIDTH];

  // Lane steering for the issue cycle.
  always_comb begin
    be_c   = 4'b1111;
    wrep_c = wdata_q;
    unique case (size_q)
      2'b00: begin
        be_c   = 4'b0001 << lane_q;
        wrep_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c   = 4'b0011 << lane_q;
        wrep_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c   = 4'b1111;
        wrep_c = wdata_q;
      end
    endcase
  end

  assign shift_c = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    ext_c = shift_c;
    unique case (size_q)
      2'b00:
        ext_c = {{24{~uns_q & shift_c[7]}}, shift_c[7:0]};
      2'b01:
        ext_c = {{16{~uns_q & shift_c[15]}}, shift_c[15:0]};
      default:
        ext_c = shift_c;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      waddr_q    <= '0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
      flt_q      <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            is_store_q <= req_is_store;
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            lane_q     <= req_addr[1:0];
            waddr_q    <= req_addr[ADDR_WIDTH-1:2];
            wdata_q    <= req_wdata;
            mis_q      <= mis_c;
            flt_q      <= flt_c;
            data_q     <= '0;
          end
        end
        ISSUE: begin
          cnt_q <= LAT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            data_q <= ext_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nx        = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_data       = '0;
    resp_misaligned = 1'b0;
    resp_fault      = 1'b0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_be          = '0;
    mem_addr        = '0;
    mem_wdata       = '0;
    unique case (state)
      IDLE: begin
        req_ready = ~rst;
        if (req_valid) begin
          state_nx = (mis_c | flt_c) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = is_store_q;
        mem_be    = be_c;
        mem_addr  = waddr_q;
        mem_wdata = wrep_c;
        state_nx  = is_store_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        resp_valid      = 1'b1;
        resp_data       = data_q;
        resp_misaligned = mis_q;
        resp_fault      = flt_q;
        if (resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table, reset/backpressure sequences
// and randomized requests against a byte-array reference model.
module tb_load_store_unit;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_misaligned, resp_fault;
  logic [31:0] resp_data;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic        b_resp_misaligned, b_resp_fault;
  logic [31:0] b_resp_data;
  logic        b_mem_en, b_mem_we;
  logic [3:0]  b_mem_be;
  logic [13:0] b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  load_store_unit #(.ADDR_WIDTH(16), .MEM_LATENCY(LAT_A)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_misaligned(resp_misaligned),
    .resp_fault(resp_fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  load_store_unit #(.ADDR_WIDTH(16), .MEM_LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_is_store(1'b0), .req_size(2'b10),
    .req_unsigned(1'b0), .req_addr(32'h0000_0300),
    .req_wdata(32'h0),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_data(b_resp_data), .resp_misaligned(b_resp_misaligned),
    .resp_fault(b_resp_fault),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // Word memory seen by the DUTs, with per-instance read latency.
  logic [31:0] dmem [0:16383];
  logic [31:0] pa;
  logic [31:0] pb [0:2];
  logic        pre_en = 1'b0;
  logic [13:0] pre_addr;
  logic [31:0] pre_data;

  assign mem_rdata   = pa;
  assign b_mem_rdata = pb[2];

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i+:8] = nw[8*i+:8];
    return r;
  endfunction

  always @(posedge clk) begin
    pa    <= dmem[mem_addr];
    pb[0] <= dmem[b_mem_addr];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
    if (pre_en)
      dmem[pre_addr] <= pre_data;
    else if (mem_en && mem_we)
      dmem[mem_addr] <= merge(dmem[mem_addr], mem_wdata, mem_be);
  end

  // Reference: byte-addressed memory and the access rules.
  logic [7:0] rmem [0:65535];

  typedef struct {
    logic        mis;
    logic        flt;
    logic [31:0] data;
    int          lat;
    int          nen;
    logic [3:0]  be;
    logic [13:0] ma;
    logic [31:0] mwd;
    logic        we;
  } exp_t;

  function automatic exp_t model(input logic st, input logic [1:0] sz,
                                 input logic un, input logic [31:0] ad,
                                 input logic [31:0] wd);
    exp_t e;
    int nb;
    logic [31:0] v;
    e = '{default: 0};
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    e.flt = (ad >> 16) != 0;
    e.mis = (nb == 0) ? 1'b1 : ((ad % nb) != 0);
    e.ma = ad[15:2];
    e.we = st;
    if (nb != 0) begin
      e.be = 4'(((1 << nb) - 1) << ad[1:0]);
      for (int i = 0; i < 4; i++)
        e.mwd[8*i+:8] = wd[8*(i%nb)+:8];
    end
    if (e.mis || e.flt) begin
      e.lat = 1;
      e.nen = 0;
    end else if (st) begin
      e.lat = 2;
      e.nen = 1;
      for (int i = 0; i < nb; i++)
        rmem[int'(ad[15:0]) + i] = wd[8*i+:8];
    end else begin
      e.lat = 2 + LAT_A;
      e.nen = 1;
      v = '0;
      for (int i = 0; i < nb; i++)
        v[8*i+:8] = rmem[int'(ad[15:0]) + i];
      if (!un && nb < 4 && v[8*nb-1])
        v = v | (32'hFFFF_FFFF << (8 * nb));
      e.data = v;
    end
    return e;
  endfunction

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] outs_a();
    return {req_ready, resp_valid, resp_data, resp_misaligned, resp_fault,
            mem_en, mem_we, mem_be, mem_addr, mem_wdata};
  endfunction

  typedef struct {
    int          lat;
    int          nen;
    int          rdy;
    logic [31:0] data;
    logic        mis;
    logic        flt;
    logic [3:0]  be;
    logic [13:0] ma;
    logic [31:0] mwd;
    logic        we;
  } obs_t;

  // One request on instance A, observed cycle by cycle from acceptance.
  task automatic do_req(input logic st, input logic [1:0] sz,
                        input logic un, input logic [31:0] ad,
                        input logic [31:0] wd, input int hold,
                        output obs_t o);
    o = '{default: 0};
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("ready_wait", req_ready, 1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = ad;
    req_wdata    = wd;
    resp_ready   = (hold == 0);
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 2'($urandom);
    req_is_store = 1'($urandom);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (req_ready) o.rdy++;
      if (mem_en) begin
        o.nen++;
        o.be  = mem_be;
        o.ma  = mem_addr;
        o.mwd = mem_wdata;
        o.we  = mem_we;
      end
      if (resp_valid) begin
        o.lat = k;
        break;
      end
    end
    if (o.lat == 0) begin
      chk("resp_timeout", resp_valid, 1);
      resp_ready = 1'b1;
      return;
    end
    o.data = resp_data;
    o.mis  = resp_misaligned;
    o.flt  = resp_fault;
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      chk("hold_stable",
          {req_ready, resp_valid, resp_data, resp_misaligned, resp_fault},
          {1'b0, 1'b1, o.data, o.mis, o.flt});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("back_idle", {req_ready, resp_valid}, 2'b10);
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] ad;
    logic [31:0] wd;
    logic        mis;
    logic        flt;
    logic [31:0] data;
    int          lat;
    int          nen;
    logic [3:0]  be;
    logic [13:0] ma;
    logic [31:0] mwd;
  } vec_t;

  vec_t tbl[17];

  initial begin
    obs_t o;
    exp_t e;
    logic [31:0] v;
    int first, en_cyc, rdy_seen, unstable;
    logic [31:0] d0;

    tbl[0]  = '{1, 2'd0, 0, 32'h0000_0103, 32'h1234_56AB, 0, 0, 32'h0, 2, 1, 4'b1000, 14'h040, 32'hABAB_ABAB};
    tbl[1]  = '{0, 2'd1, 0, 32'h0000_0202, 32'h0, 0, 0, 32'hFFFF_80F0, 3, 1, 4'b1100, 14'h080, 32'h0};
    tbl[2]  = '{0, 2'd1, 1, 32'h0000_0202, 32'h0, 0, 0, 32'h0000_80F0, 3, 1, 4'b1100, 14'h080, 32'h0};
    tbl[3]  = '{0, 2'd0, 0, 32'h0000_0201, 32'h0, 0, 0, 32'h0000_007F, 3, 1, 4'b0010, 14'h080, 32'h0};
    tbl[4]  = '{0, 2'd2, 0, 32'h0000_0102, 32'h0, 1, 0, 32'h0, 1, 0, 4'b0, 14'h0, 32'h0};
    tbl[5]  = '{0, 2'd3, 0, 32'h0000_0000, 32'h0, 1, 0, 32'h0, 1, 0, 4'b0, 14'h0, 32'h0};
    tbl[6]  = '{1, 2'd2, 0, 32'h0001_0000, 32'h5, 0, 1, 32'h0, 1, 0, 4'b0, 14'h0, 32'h0};
    tbl[7]  = '{0, 2'd0, 1, 32'h0000_0203, 32'h0, 0, 0, 32'h0000_0080, 3, 1, 4'b1000, 14'h080, 32'h0};
    tbl[8]  = '{0, 2'd0, 0, 32'h0000_0203, 32'h0, 0, 0, 32'hFFFF_FF80, 3, 1, 4'b1000, 14'h080, 32'h0};
    tbl[9]  = '{0, 2'd2, 0, 32'h0000_0200, 32'h0, 0, 0, 32'h80F0_7F01, 3, 1, 4'b1111, 14'h080, 32'h0};
    tbl[10] = '{1, 2'd1, 0, 32'h0000_0106, 32'hDEAD_BEEF, 0, 0, 32'h0, 2, 1, 4'b1100, 14'h041, 32'hBEEF_BEEF};
    tbl[11] = '{0, 2'd1, 0, 32'h0000_0106, 32'h0, 0, 0, 32'hFFFF_BEEF, 3, 1, 4'b1100, 14'h041, 32'h0};
    tbl[12] = '{0, 2'd2, 0, 32'h0001_0001, 32'h0, 1, 1, 32'h0, 1, 0, 4'b0, 14'h0, 32'h0};
    tbl[13] = '{1, 2'd2, 0, 32'h0000_0104, 32'h1122_3344, 0, 0, 32'h0, 2, 1, 4'b1111, 14'h041, 32'h1122_3344};
    tbl[14] = '{0, 2'd0, 1, 32'h0000_0105, 32'h0, 0, 0, 32'h0000_0033, 3, 1, 4'b0010, 14'h041, 32'h0};
    tbl[15] = '{0, 2'd0, 0, 32'h0000_0103, 32'h0, 0, 0, 32'hFFFF_FFAB, 3, 1, 4'b1000, 14'h040, 32'h0};
    tbl[16] = '{0, 2'd1, 1, 32'h0000_0104, 32'h0, 0, 0, 32'h0000_3344, 3, 1, 4'b0011, 14'h041, 32'h0};

    req_valid = 0; req_is_store = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; resp_ready = 1;
    b_req_valid = 0; b_resp_ready = 0;
    pre_addr = 0; pre_data = 0;

    #1 rst = 1'b1;
    #1;
    chk("reset_outs_a", outs_a(), 128'h0);
    chk("reset_outs_b",
        {b_req_ready, b_resp_valid, b_resp_data, b_mem_en, b_mem_be},
        39'h0);

    // Preload words 0x40..0xFF of both memories while in reset.
    for (int w = 'h40; w < 'h100; w++) begin
      @(negedge clk);
      v = $urandom;
      if (w == 'h80) v = 32'h80F0_7F01;
      if (w == 'hC0) v = 32'hCAFE_F00D;
      pre_en = 1'b1;
      pre_addr = 14'(w);
      pre_data = v;
      for (int i = 0; i < 4; i++) rmem[4*w+i] = v[8*i+:8];
    end
    @(negedge clk);
    pre_en = 1'b0;
    chk("in_reset_outs", outs_a(), 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {req_ready, resp_valid}, 2'b10);

    foreach (tbl[i]) begin
      e = model(tbl[i].st, tbl[i].sz, tbl[i].un, tbl[i].ad, tbl[i].wd);
      do_req(tbl[i].st, tbl[i].sz, tbl[i].un, tbl[i].ad, tbl[i].wd,
             i % 3, o);
      chk($sformatf("v%0d_lat", i), o.lat, tbl[i].lat);
      chk($sformatf("v%0d_data", i), o.data, tbl[i].data);
      chk($sformatf("v%0d_flags", i), {o.mis, o.flt},
          {tbl[i].mis, tbl[i].flt});
      chk($sformatf("v%0d_nen", i), o.nen, tbl[i].nen);
      chk($sformatf("v%0d_busy", i), o.rdy, 0);
      if (tbl[i].nen != 0) begin
        chk($sformatf("v%0d_be", i), o.be, tbl[i].be);
        chk($sformatf("v%0d_maddr", i), o.ma, tbl[i].ma);
        chk($sformatf("v%0d_we", i), o.we, tbl[i].st);
        chk($sformatf("v%0d_mwdata", i), o.mwd, tbl[i].mwd);
      end
    end

    // Reset while waiting on a load: outputs clear, nothing stale after.
    req_valid = 1; req_is_store = 0; req_size = 2'd2;
    req_addr = 32'h200; resp_ready = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("rst_wait_issue", mem_en, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_wait_outs", outs_a(), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_stale", {req_ready, resp_valid, mem_en}, 3'b100);
    end

    // Reset during a store issue: the write strobe drops at once.
    req_valid = 1; req_is_store = 1; req_size = 2'd2;
    req_addr = 32'h180; req_wdata = 32'h5A5A_5A5A;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("rst_issue_strobe", {mem_en, mem_we}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rst_issue_drop", {mem_en, mem_we, mem_be}, 6'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    e = model(1'b0, 2'd2, 1'b0, 32'h180, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h180, 32'h0, 0, o);
    chk("abandoned_store", o.data, e.data);

    // Latency 3 instance with response backpressure.
    @(negedge clk);
    b_req_valid = 1'b1;
    b_resp_ready = 1'b0;
    chk("b_ready", b_req_ready, 1);
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    first = 0; en_cyc = 0; rdy_seen = 0; unstable = 0; d0 = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (b_req_ready) rdy_seen++;
      if (b_mem_en) begin
        en_cyc = k;
        chk("b_issue", {b_mem_we, b_mem_be, b_mem_addr, b_mem_wdata},
            {1'b0, 4'b1111, 14'h0C0, 32'h0});
      end
      if (b_resp_valid && first == 0) begin
        first = k;
        d0 = b_resp_data;
        chk("b_flags", {b_resp_misaligned, b_resp_fault}, 2'b00);
      end else if (first != 0 && (!b_resp_valid || b_resp_data != d0)) begin
        unstable++;
      end
    end
    b_resp_ready = 1'b1;
    chk("b_mem_en_cycle", en_cyc, 1);
    chk("b_first_valid", first, 2 + LAT_B);
    chk("b_data", d0, 32'hCAFE_F00D);
    chk("b_stable", unstable, 0);
    chk("b_busy", rdy_seen, 0);
    @(negedge clk);
    chk("b_idle", {b_req_ready, b_resp_valid}, 2'b10);

    // Random requests against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic        st, un;
      logic [1:0]  sz;
      logic [31:0] ad, wd;
      int          r;
      st = 1'($urandom);
      un = 1'($urandom);
      r  = $urandom_range(0, 15);
      sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      ad = 32'h100 + $urandom_range(0, 'h2FF);
      if ($urandom_range(0, 7) == 0) ad = ad | ({$urandom} << 16);
      wd = $urandom;
      e = model(st, sz, un, ad, wd);
      do_req(st, sz, un, ad, wd, $urandom_range(0, 2), o);
      chk("rnd_lat", o.lat, e.lat);
      chk("rnd_data", o.data, e.data);
      chk("rnd_flags", {o.mis, o.flt}, {e.mis, e.flt});
      chk("rnd_nen", o.nen, e.nen);
      if (e.nen != 0) begin
        chk("rnd_be", o.be, e.be);
        chk("rnd_maddr", o.ma, e.ma);
        chk("rnd_we", o.we, e.we);
        if (st) chk("rnd_mwdata", o.mwd, e.mwd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
